// File: rtl/sync_up_counter_4bit.sv
`default_nettype none
// ==========================================================================
// sync_up_counter_4bit -- loadable up counter, runtime terminal value, cascade
// carry; define GRAY_OUT_EN to add a registered Gray-coded copy (out_gray).
// Rev 1.0
// ==========================================================================
module sync_up_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             co
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] out_gray
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] next_count;
  logic             next_tc;
  logic             wrap;

  // Reaching max_val wraps; so does the natural rollover when a load or a
  // max_val change has left the count above the terminal value.
  assign wrap = (out == max_val) || (out == ALL_ONES);

  always_comb begin
    next_count = out;
    next_tc    = 1'b0;
    if (load) begin
      next_count = load_val;
    end else if (en) begin
      if (wrap) begin
        next_count = '0;
        next_tc    = 1'b1;
      end else begin
        next_count = out + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= '0;
      tc  <= 1'b0;
    end else begin
      out <= next_count;
      tc  <= next_tc;
    end
  end

  assign co = en & ~load & (out == max_val);

`ifdef GRAY_OUT_EN
  // Encoded from next_count so the Gray value lands in the same cycle as out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_gray <= '0;
    end else begin
      out_gray <= next_count ^ (next_count >> 1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/sync_up_counter_4bit.md
SYNC_UP_COUNTER_4BIT -- requirements
Module: sync_up_counter_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstn  input  1  reset; asynchronous, active-low.
REQ-004 Port: en  input  1  count enable; counter advances by one on each rising clk edge while high.
REQ-005 Port: load  input  1  synchronous parallel load; takes priority over en.
REQ-006 Port: load_val  input  WIDTH  value captured into the counter when load is high.
REQ-007 Port: max_val  input  WIDTH  runtime terminal value; the count after max_val is 0.
REQ-008 Port: out  output  WIDTH  registered count value.
REQ-009 Port: tc  output  1  registered terminal-count flag; high for exactly one cycle after each wrap to 0.
REQ-010 Port: co  output  1  combinational cascade carry: en & ~load & (out == max_val).

Function
REQ-011 The counter SHALL be fully synchronous; every flop SHALL be clocked by clk only, with no derived or rippled clocks.
REQ-012 Priority per edge SHALL be: load, then en, then hold.
REQ-013 With load=1, out SHALL take load_val on the next edge and tc SHALL be 0, regardless of en.
REQ-014 With load=0, en=1, and out==max_val, out SHALL become 0 and tc SHALL be 1 on the next edge.
REQ-015 With load=0, en=1, and out!=max_val, out SHALL become out+1 modulo 2^WIDTH and tc SHALL be 0.
REQ-016 Boundary: if out>max_val (reachable only via load or a max_val change), the counter SHALL count up to 2^WIDTH-1, wrap to 0 with tc=1, then honour max_val.
REQ-017 Boundary: max_val=0 with en held high SHALL hold out at 0, with tc=1 every cycle.
REQ-018 With en=0 and load=0, out SHALL hold and tc SHALL be 0 on the next edge.
REQ-019 max_val SHALL be sampled every cycle; a change takes effect on the next comparison with no pipeline delay.
REQ-020 Latency: every input-to-out and input-to-tc path SHALL be one clock; co SHALL have zero latency.
REQ-021 Two instances cascaded, with the upper en driven by the lower co, SHALL form a synchronous 2*WIDTH-bit counter with no extra cycle of skew.

Reset
REQ-022 rstn=0 SHALL immediately force out=0 and tc=0, independent of clk.
REQ-023 Reset assertion mid-count SHALL discard the count; a load pending in the same cycle SHALL be ignored.
REQ-024 On rstn deassertion, the first counting edge SHALL produce out=1, given en=1, load=0 and max_val!=0.

Configuration
REQ-025 Macro GRAY_OUT_EN: when defined, the module SHALL add output out_gray (WIDTH bits), registered, equal to out ^ (out >> 1) in the same cycle as out, and reset to 0.
REQ-026 With GRAY_OUT_EN undefined, the out_gray port and its register SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then en=1, max_val=15, 17 clocks -> out steps 1..15, 0, 1; tc=1 only in the cycle after 15->0.
REQ-028 max_val=9, en=1 from 0 -> out wraps 9->0 (decade count); co high exactly while out==9.
REQ-029 load=1, load_val=12, en=1, max_val=5 -> out=12, then 13, 14, 15, 0 (tc=1), 1..5, 0.
REQ-030 Assert rstn=0 asynchronously mid-cycle at out=7 -> out=0 and tc=0 before the next edge; with load=1 held through reset, out=0 persists until the first edge after release.
REQ-031 Two WIDTH=4 instances cascaded via co, max_val=15, 256 clocks -> combined count 0x00..0xFF, then 0x00, with no skipped or duplicated values.
REQ-032 GRAY_OUT_EN defined, count 0..15 -> out_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, with exactly one bit changing per step.
